ataque_iniciador: RTL and testbench

ATAQUE_INICIADOR -- requirements
Module: ataque_iniciador

---
 rtl/ataque_iniciador_pkg.sv | 32 +++
 rtl/serial_bit_timer.sv | 69 ++++++
 rtl/ataque_iniciador.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ataque_iniciador.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ataque_iniciador_pkg.sv
// Shared definitions for the attacking side of the serial battleship link.
// Holds the FSM state encoding, board dimensions, frame lengths and the
// cell-index helpers used by the initiator (and by a future responder).
package ataque_iniciador_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    TX_START = 3'd1,
    TX_DADOS = 3'd2,
    TX_STOP  = 3'd3,
    AGUARDA  = 3'd4,
    RX_DADO  = 3'd5,
    RX_STOP  = 3'd6
  } estado_t;

  localparam int N_LINHAS         = 7;
  localparam int N_COLUNAS        = 5;
  localparam int N_CELULAS        = 35;
  localparam int REQ_BITS_DADOS   = 6;   // {linha, coluna}
  localparam int REQ_BITS_QUADRO  = 8;   // start + 6 data + stop
  localparam int RESP_BITS_QUADRO = 3;   // start + hit + stop

  // Flat cell index: linha*5 + coluna.
  function automatic logic [5:0] indice_celula(input logic [2:0] lin, input logic [2:0] col);
    return ({3'd0, lin} * 6'd5) + {3'd0, col};
  endfunction

  function automatic logic coord_valida(input logic [2:0] lin, input logic [2:0] col);
    return (lin < 3'(N_LINHAS)) && (col < 3'(N_COLUNAS));
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Serial bit timer plus shift register, shared by the initiator and responder.
// Ports:
//   clk, rstn     clock, async active-low reset
//   recarga_i     reload the down-counter with carga_i (state entry / new bit)
//   carga_i       number of cycles the current bit/interval lasts (>= 1)
//   expirou_o     high on the last cycle of the loaded interval
//   carregar_i    parallel load of dado_i into the shift register
//   deslocar_i    shift right one place, serial_i enters at the MSB
//   dado_o        shift register contents (bit 0 is the next bit out)
module serial_bit_timer
  import ataque_iniciador_pkg::*;
#(
  parameter int LARG_CNT   = 11,
  parameter int LARG_DADOS = REQ_BITS_DADOS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  recarga_i,
  input  logic [LARG_CNT-1:0]   carga_i,
  output logic                  expirou_o,
  input  logic                  carregar_i,
  input  logic [LARG_DADOS-1:0] dado_i,
  input  logic                  deslocar_i,
  input  logic                  serial_i,
  output logic [LARG_DADOS-1:0] dado_o
);

  logic [LARG_CNT-1:0]   cnt_q, cnt_d;
  logic [LARG_DADOS-1:0] desl_q, desl_d;

  // Counter holds N-1 after a reload so the interval lasts exactly N cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (recarga_i) begin
      cnt_d = carga_i - LARG_CNT'(1);
    end else if (cnt_q != {LARG_CNT{1'b0}}) begin
      cnt_d = cnt_q - LARG_CNT'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Shift register next value: parallel load wins over shift.
  always_comb begin
    desl_d = desl_q;
    if (carregar_i) begin
      desl_d = dado_i;
    end else if (deslocar_i) begin
      desl_d = {serial_i, desl_q[LARG_DADOS-1:1]};
    end else begin
      desl_d = desl_q;
    end
  end

  // Counter and shift register state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= {LARG_CNT{1'b0}};
      desl_q <= {LARG_DADOS{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      desl_q <= desl_d;
    end
  end

  assign expirou_o = (cnt_q == {LARG_CNT{1'b0}});
  assign dado_o    = desl_q;

endmodule

// File: rtl/ataque_iniciador.sv
// Attacking-side initiator: validates a shot, sends {linha,coluna} serially,
// waits for the hit/miss response and keeps the shot and hit maps.
// Ports:
//   clk, rstn               clock, async active-low reset
//   habilitar               attack mode; dropping it aborts to idle
//   linha, coluna, disparo  target cell and fire button (rising edge fires)
//   limpar                  clear maps and acerto while idle
//   rx / tx                 serial response in / request out (idle high)
//   ocupado                 not idle
//   resultado_valido, acerto, erro_coord, falha   result flags/pulses
//   mapa_tiros, mapa_acertos                      per-cell fired / hit maps
module ataque_iniciador
  import ataque_iniciador_pkg::*;
#(
  parameter int BIT_CICLOS     = 4,
  parameter int TIMEOUT_CICLOS = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 habilitar,
  input  logic [2:0]           linha,
  input  logic [2:0]           coluna,
  input  logic                 disparo,
  input  logic                 limpar,
  input  logic                 rx,
  output logic                 tx,
  output logic                 ocupado,
  output logic                 resultado_valido,
  output logic                 acerto,
  output logic                 erro_coord,
  output logic                 falha,
  output logic [N_CELULAS-1:0] mapa_tiros,
  output logic [N_CELULAS-1:0] mapa_acertos
);

  localparam int LARG_CNT   = $clog2(TIMEOUT_CICLOS + BIT_CICLOS + 1);
  // A marker bit above the data: once only the marker is left, all data bits are out.
  localparam int LARG_DESL  = REQ_BITS_DADOS + 1;
  localparam logic [LARG_DESL-1:0] SO_MARCADOR = {{(LARG_DESL-1){1'b0}}, 1'b1};

  estado_t               estado_q, estado_d;
  logic                  tx_q, tx_d;
  logic                  ocupado_q;
  logic [2:0]            lin_q, lin_d, col_q, col_d;
  logic                  confirma_q, confirma_d;
  logic [LARG_CNT-1:0]   meia_q, meia_d;
  logic                  dado_rx_q, dado_rx_d;
  logic [N_CELULAS-1:0]  mapa_tiros_q, mapa_tiros_d, mapa_acertos_q, mapa_acertos_d;
  logic                  acerto_q, acerto_d;
  logic                  res_val_q, res_val_d, erro_q, erro_d, falha_q, falha_d;
  logic                  disparo_q, rx_meta_q, rx_sinc_q;

  logic                  borda_s, expirou_s, recarga_s, recarga_bit_s;
  logic                  carregar_s, deslocar_s, ja_disparado_s;
  logic [LARG_CNT-1:0]   carga_s;
  logic [LARG_DESL-1:0]  dado_s;
  logic [5:0]            idx_alvo_s, idx_tiro_s;

  assign borda_s        = disparo & ~disparo_q;
  assign idx_alvo_s     = indice_celula(linha, coluna);
  assign idx_tiro_s     = indice_celula(lin_q, col_q);
  assign ja_disparado_s = coord_valida(linha, coluna) ? mapa_tiros_q[idx_alvo_s] : 1'b0;
  // The single timer is reloaded on every state change and for each new data bit.
  assign recarga_s      = (estado_d != estado_q) | recarga_bit_s;
  assign carga_s        = (estado_d == AGUARDA) ? LARG_CNT'(TIMEOUT_CICLOS) : LARG_CNT'(BIT_CICLOS);

  serial_bit_timer #(
    .LARG_CNT   (LARG_CNT),
    .LARG_DADOS (LARG_DESL)
  ) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .recarga_i  (recarga_s),
    .carga_i    (carga_s),
    .expirou_o  (expirou_s),
    .carregar_i (carregar_s),
    .dado_i     ({1'b1, linha, coluna}),
    .deslocar_i (deslocar_s),
    .serial_i   (1'b0),
    .dado_o     (dado_s)
  );

  // Next-state, serial output, map and pulse logic.
  always_comb begin
    estado_d       = estado_q;
    tx_d           = tx_q;
    lin_d          = lin_q;
    col_d          = col_q;
    confirma_d     = confirma_q;
    meia_d         = meia_q;
    dado_rx_d      = dado_rx_q;
    mapa_tiros_d   = mapa_tiros_q;
    mapa_acertos_d = mapa_acertos_q;
    acerto_d       = acerto_q;
    res_val_d      = 1'b0;
    erro_d         = 1'b0;
    falha_d        = 1'b0;
    carregar_s     = 1'b0;
    deslocar_s     = 1'b0;
    recarga_bit_s  = 1'b0;
    if ((estado_q != OCIOSO) && !habilitar) begin
      estado_d   = OCIOSO;
      tx_d       = 1'b1;
      confirma_d = 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          tx_d       = 1'b1;
          confirma_d = 1'b0;
          // limpar has priority, so a simultaneous shot is dropped.
          if (limpar) begin
            mapa_tiros_d   = {N_CELULAS{1'b0}};
            mapa_acertos_d = {N_CELULAS{1'b0}};
            acerto_d       = 1'b0;
          end else if (borda_s && habilitar) begin
            if (!coord_valida(linha, coluna) || ja_disparado_s) begin
              erro_d = 1'b1;
            end else begin
              lin_d      = linha;
              col_d      = coluna;
              carregar_s = 1'b1;
              estado_d   = TX_START;
              tx_d       = 1'b0;
            end
          end else begin
            estado_d = OCIOSO;
          end
        end
        TX_START: begin
          if (expirou_s) begin
            estado_d   = TX_DADOS;
            tx_d       = dado_s[0];
            deslocar_s = 1'b1;
          end else begin
            tx_d = 1'b0;
          end
        end
        TX_DADOS: begin
          if (expirou_s && (dado_s == SO_MARCADOR)) begin
            estado_d = TX_STOP;
            tx_d     = 1'b1;
          end else if (expirou_s) begin
            tx_d          = dado_s[0];
            deslocar_s    = 1'b1;
            recarga_bit_s = 1'b1;
          end else begin
            tx_d = tx_q;
          end
        end
        TX_STOP: begin
          tx_d = 1'b1;
          if (expirou_s) begin
            estado_d   = AGUARDA;
            confirma_d = 1'b0;
          end else begin
            estado_d = TX_STOP;
          end
        end
        AGUARDA: begin
          // A confirmation due on the same cycle as the timeout takes precedence.
          if (confirma_q && (meia_q == {LARG_CNT{1'b0}})) begin
            confirma_d = 1'b0;
            if (!rx_sinc_q) begin
              estado_d = RX_DADO;
            end else begin
              estado_d = AGUARDA;
            end
          end else if (expirou_s) begin
            estado_d   = OCIOSO;
            falha_d    = 1'b1;
            confirma_d = 1'b0;
          end else if (confirma_q) begin
            meia_d = meia_q - LARG_CNT'(1);
          end else if (!rx_sinc_q) begin
            confirma_d = 1'b1;
            meia_d     = LARG_CNT'(BIT_CICLOS / 2 - 1);
          end else begin
            confirma_d = 1'b0;
          end
        end
        RX_DADO: begin
          if (expirou_s) begin
            dado_rx_d = rx_sinc_q;
            estado_d  = RX_STOP;
          end else begin
            estado_d = RX_DADO;
          end
        end
        RX_STOP: begin
          if (expirou_s && rx_sinc_q) begin
            estado_d                 = OCIOSO;
            mapa_tiros_d[idx_tiro_s] = 1'b1;
            if (dado_rx_q) begin
              mapa_acertos_d[idx_tiro_s] = 1'b1;
            end else begin
              mapa_acertos_d = mapa_acertos_q;
            end
            acerto_d  = dado_rx_q;
            res_val_d = 1'b1;
          end else if (expirou_s) begin
            estado_d = OCIOSO;
            falha_d  = 1'b1;
          end else begin
            estado_d = RX_STOP;
          end
        end
        default: begin
          estado_d = OCIOSO;
          tx_d     = 1'b1;
        end
      endcase
    end
  end

  // Input conditioning: fire-button delay copy and 2-flop rx synchroniser.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disparo_q <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_sinc_q <= 1'b1;
    end else begin
      disparo_q <= disparo;
      rx_meta_q <= rx;
      rx_sinc_q <= rx_meta_q;
    end
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      estado_q       <= OCIOSO;
      tx_q           <= 1'b1;
      ocupado_q      <= 1'b0;
      lin_q          <= 3'd0;
      col_q          <= 3'd0;
      confirma_q     <= 1'b0;
      meia_q         <= {LARG_CNT{1'b0}};
      dado_rx_q      <= 1'b0;
      mapa_tiros_q   <= {N_CELULAS{1'b0}};
      mapa_acertos_q <= {N_CELULAS{1'b0}};
      acerto_q       <= 1'b0;
      res_val_q      <= 1'b0;
      erro_q         <= 1'b0;
      falha_q        <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      tx_q           <= tx_d;
      ocupado_q      <= (estado_d != OCIOSO);
      lin_q          <= lin_d;
      col_q          <= col_d;
      confirma_q     <= confirma_d;
      meia_q         <= meia_d;
      dado_rx_q      <= dado_rx_d;
      mapa_tiros_q   <= mapa_tiros_d;
      mapa_acertos_q <= mapa_acertos_d;
      acerto_q       <= acerto_d;
      res_val_q      <= res_val_d;
      erro_q         <= erro_d;
      falha_q        <= falha_d;
    end
  end

  assign tx               = tx_q;
  assign ocupado          = ocupado_q;
  assign resultado_valido = res_val_q;
  assign acerto           = acerto_q;
  assign erro_coord       = erro_q;
  assign falha            = falha_q;
  assign mapa_tiros       = mapa_tiros_q;
  assign mapa_acertos     = mapa_acertos_q;

endmodule

// File: tb/tb_ataque_iniciador.sv
// Scoreboard bench for ataque_iniciador (BIT_CICLOS=4, TIMEOUT_CICLOS=64).
// Stimulus pushes expected events; a negedge monitor pops and compares them.
module tb_ataque_iniciador;

  logic        clk = 1'b0;
  logic        rstn, habilitar, disparo, limpar, rx;
  logic [2:0]  linha, coluna;
  logic        tx, ocupado, resultado_valido, acerto, erro_coord, falha;
  logic [34:0] mapa_tiros, mapa_acertos;

  localparam int EV_QUADRO = 0;
  localparam int EV_RESULT = 1;
  localparam int EV_ERRO   = 2;
  localparam int EV_FALHA  = 3;

  typedef struct {
    int          tipo;
    logic [7:0]  seq;
    int          corte;
    logic        acerto;
    logic [34:0] tiros;
    logic [34:0] acertos;
    int          atraso;
  } ev_t;

  ev_t         fila[$];
  int          total = 0;
  int          bad   = 0;
  logic [34:0] mod_tiros, mod_acertos;

  always #5 clk = ~clk;

  ataque_iniciador #(.BIT_CICLOS(4), .TIMEOUT_CICLOS(64)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .habilitar        (habilitar),
    .linha            (linha),
    .coluna           (coluna),
    .disparo          (disparo),
    .limpar           (limpar),
    .rx               (rx),
    .tx               (tx),
    .ocupado          (ocupado),
    .resultado_valido (resultado_valido),
    .acerto           (acerto),
    .erro_coord       (erro_coord),
    .falha            (falha),
    .mapa_tiros       (mapa_tiros),
    .mapa_acertos     (mapa_acertos)
  );

  task automatic verifica(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    total++;
    if (atual !== esperado) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
    end
  endtask

  function automatic logic [7:0] quadro(input logic [2:0] l, input logic [2:0] c);
    return {1'b1, l, c, 1'b0};
  endfunction

  task automatic espera(input int tipo, input logic [7:0] seq, input int corte,
                        input logic ac, input int atraso);
    ev_t e;
    e.tipo = tipo; e.seq = seq; e.corte = corte; e.acerto = ac;
    e.tiros = mod_tiros; e.acertos = mod_acertos; e.atraso = atraso;
    fila.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disparar(input logic [2:0] l, input logic [2:0] c);
    linha = l; coluna = c; disparo = 1'b1;
    tick();
    disparo = 1'b0;
  endtask

  task automatic responde(input logic hit, input logic stop);
    rx = 1'b0; repeat (4) tick();
    rx = hit;  repeat (4) tick();
    rx = stop; repeat (4) tick();
    rx = 1'b1;
  endtask

  // Monitor: decode tx frames and pulses, compare against the queue head.
  int          cyc = 0;
  int          ini = 0;
  int          cidx = 0;
  logic        capt = 1'b0;
  logic [31:0] capv;

  task automatic confere(input int obs, input logic [31:0] cap);
    ev_t         e;
    logic [31:0] esp;
    if (fila.size() == 0) begin
      total++; bad++;
      $display("FAIL evento_inesperado: got kind %0d expected none", obs);
    end else begin
      e = fila.pop_front();
      verifica("tipo_evento", obs, e.tipo);
      if (e.tipo == obs && obs == EV_QUADRO) begin
        for (int j = 0; j < 32; j++) esp[j] = (j < e.corte) ? e.seq[j/4] : 1'b1;
        verifica("quadro_tx", cap, esp);
      end else if (e.tipo == obs && obs == EV_RESULT) begin
        verifica("acerto", acerto, e.acerto);
        verifica("mapa_tiros_res", mapa_tiros, e.tiros);
        verifica("mapa_acertos_res", mapa_acertos, e.acertos);
      end else if (e.tipo == obs && obs == EV_FALHA) begin
        verifica("mapa_tiros_falha", mapa_tiros, e.tiros);
        verifica("mapa_acertos_falha", mapa_acertos, e.acertos);
        if (e.atraso >= 0) verifica("atraso_falha", cyc - ini, e.atraso);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      capt = 1'b0;
    end else begin
      if (!capt && tx == 1'b0) begin
        capt = 1'b1; cidx = 0; capv = 32'd0; ini = cyc;
      end
      if (capt) begin
        capv[cidx] = tx;
        cidx++;
        if (cidx == 32) begin
          capt = 1'b0;
          confere(EV_QUADRO, capv);
        end
      end
      if (resultado_valido) confere(EV_RESULT, 32'd0);
      if (erro_coord)       confere(EV_ERRO, 32'd0);
      if (falha)            confere(EV_FALHA, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; habilitar = 1'b0; disparo = 1'b0; limpar = 1'b0; rx = 1'b1;
    linha = 3'd0; coluna = 3'd0;
    mod_tiros = 35'd0; mod_acertos = 35'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    verifica("reset_tx", tx, 1);
    verifica("reset_ocupado", ocupado, 0);
    verifica("reset_mapa_tiros", mapa_tiros, 0);
    verifica("reset_mapa_acertos", mapa_acertos, 0);
    verifica("reset_acerto", acerto, 0);
    verifica("reset_pulsos", {resultado_valido, erro_coord, falha}, 0);
    tick(); rstn = 1'b1; habilitar = 1'b1;
    repeat (2) tick();

    // Shot at (2,3): frame 0,1,1,0,0,1,0,1; hit response.
    espera(EV_QUADRO, 8'b10100110, 32, 1'b0, -1);
    disparar(3'd2, 3'd3);
    @(negedge clk);
    verifica("ocupado_tx", ocupado, 1);
    repeat (38) tick();
    mod_tiros[13] = 1'b1; mod_acertos[13] = 1'b1;
    espera(EV_RESULT, 8'd0, 0, 1'b1, -1);
    responde(1'b1, 1'b1);
    repeat (10) tick();

    // Rejections: repeat cell 13, linha 7, coluna 5.
    espera(EV_ERRO, 8'd0, 0, 1'b0, -1); disparar(3'd2, 3'd3); tick();
    espera(EV_ERRO, 8'd0, 0, 1'b0, -1); disparar(3'd7, 3'd0); tick();
    espera(EV_ERRO, 8'd0, 0, 1'b0, -1); disparar(3'd0, 3'd5);
    repeat (3) tick();
    verifica("ocupado_rejeicao", ocupado, 0);

    // Shot at (0,0) with a discarded edge mid-frame; miss response.
    espera(EV_QUADRO, quadro(3'd0, 3'd0), 32, 1'b0, -1);
    disparar(3'd0, 3'd0);
    repeat (3) tick(); disparo = 1'b1;
    repeat (2) tick(); disparo = 1'b0;
    repeat (34) tick();
    mod_tiros[0] = 1'b1;
    espera(EV_RESULT, 8'd0, 0, 1'b0, -1);
    responde(1'b0, 1'b1);
    repeat (10) tick();

    // Shot at (6,4), no response: timeout 64 cycles after the stop bit.
    espera(EV_QUADRO, quadro(3'd6, 3'd4), 32, 1'b0, -1);
    espera(EV_FALHA, 8'd0, 0, 1'b0, 96);
    disparar(3'd6, 3'd4);
    repeat (110) tick();

    // Shot at (1,1), response with stop bit 0: framing error.
    espera(EV_QUADRO, quadro(3'd1, 3'd1), 32, 1'b0, -1);
    disparar(3'd1, 3'd1);
    repeat (39) tick();
    espera(EV_FALHA, 8'd0, 0, 1'b0, -1);
    responde(1'b1, 1'b0);
    repeat (10) tick();

    // Abort: habilitar dropped in the second data bit.
    espera(EV_QUADRO, quadro(3'd3, 3'd2), 10, 1'b0, -1);
    linha = 3'd3; coluna = 3'd2; disparo = 1'b1;
    repeat (10) tick();
    habilitar = 1'b0;
    tick();
    @(negedge clk);
    verifica("abort_ocupado", ocupado, 0);
    verifica("abort_tx", tx, 1);
    tick(); habilitar = 1'b1; disparo = 1'b0;
    repeat (40) tick();
    verifica("abort_mapa_tiros", mapa_tiros, mod_tiros);

    // Reset pulsed while waiting for the response.
    espera(EV_QUADRO, quadro(3'd4, 3'd4), 32, 1'b0, -1);
    disparar(3'd4, 3'd4);
    repeat (39) tick();
    rstn = 1'b0;
    #1;
    verifica("rst_meio_tx", tx, 1);
    verifica("rst_meio_ocupado", ocupado, 0);
    verifica("rst_meio_mapa", mapa_tiros, 0);
    mod_tiros = 35'd0; mod_acertos = 35'd0;
    tick(); rstn = 1'b1;
    @(negedge clk);
    verifica("pos_rst_tx", tx, 1);
    verifica("pos_rst_ocupado", ocupado, 0);
    repeat (3) tick();

    // Same cell accepted again after reset; hit.
    espera(EV_QUADRO, quadro(3'd4, 3'd4), 32, 1'b0, -1);
    disparar(3'd4, 3'd4);
    repeat (38) tick();
    mod_tiros[24] = 1'b1; mod_acertos[24] = 1'b1;
    espera(EV_RESULT, 8'd0, 0, 1'b1, -1);
    responde(1'b1, 1'b1);
    repeat (10) tick();

    // limpar together with a valid disparo edge: maps cleared, no frame.
    linha = 3'd5; coluna = 3'd0; limpar = 1'b1; disparo = 1'b1;
    tick();
    limpar = 1'b0; disparo = 1'b0;
    @(negedge clk);
    verifica("limpar_mapa_tiros", mapa_tiros, 0);
    verifica("limpar_mapa_acertos", mapa_acertos, 0);
    verifica("limpar_acerto", acerto, 0);
    verifica("limpar_ocupado", ocupado, 0);
    repeat (40) tick();

    verifica("fila_vazia", fila.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
